fifo_read_arbiter: RTL and testbench

- Shares the single read port of the audio sample FIFO among NREQ consumers, such as per-channel effect units.
- Grants are round-robin and bounded by burst length.
- Generates the gated FIFO read strobe and routes returned data to the granted consumer with a per-requester valid.
- Sits between the FIFO read-pointer/memory and the effect processing units.

---
 rtl/fifo_read_arbiter_if.sv | 51 +++++
 rtl/fifo_read_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_read_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_read_arbiter_if
// Bundle between the audio sample FIFO read side, the consumers and the
// read arbiter.
//
//   req        consumers -> arbiter   per-requester read request (level)
//   fifo_empty FIFO      -> arbiter   FIFO empty flag
//   fifo_rdata FIFO      -> arbiter   read data, valid one cycle after fifo_rd
//   fifo_rd    arbiter   -> FIFO      read strobe, one word per high cycle
//   gnt        arbiter   -> consumers one-hot registered grant
//   rvalid     arbiter   -> consumers one-hot "rdata is yours this cycle"
//   rdata      arbiter   -> consumers returned sample
//   busy       arbiter   -> system    high while a burst is in progress
//
// master: the environment side (FIFO + consumers); slave: the arbiter.
// -----------------------------------------------------------------------------
interface fifo_read_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0] req;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_rdata;
    logic            fifo_rd;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;

    modport master (
        output req,
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  busy
    );

    modport slave (
        input  req,
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd,
        output gnt,
        output rvalid,
        output rdata,
        output busy
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_read_arbiter
// Shares the single read port of the audio sample FIFO among NREQ consumers.
// Round-robin grants, each limited to BURST_MAX reads; the arbiter gates the
// FIFO read strobe and tags the returned data with a per-requester valid.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_read_arbiter_if.slave (req, fifo_empty, fifo_rdata in;
//          fifo_rd, gnt, rvalid, rdata, busy out)
//
// States:
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbitration cycle, gnt=0; picks the next requester after last
//   BURST | one requester granted; reads while its req is high and the
//         | FIFO is not empty, at most BURST_MAX words
// -----------------------------------------------------------------------------
module fifo_read_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_read_arbiter_if.slave  bus
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   left_q, left_d;
    logic [NREQ-1:0] rvalid_q;

    logic            sel_found;
    logic [LW-1:0]   sel_idx;
    logic [LW-1:0]   cand_idx;
    int              cand;
    logic            granted_req;
    logic            rd;

    // Round-robin pick: scan last+1, last+2, ... (mod NREQ).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last_q) + i) % NREQ;
            cand_idx = LW'(cand);
            if (!sel_found && bus.req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign granted_req = |(bus.req & gnt_q);

    // Strobe is gated by state as well as gnt so it drops with the async reset.
    assign rd = (state_q == BURST) && granted_req && !bus.fifo_empty;

    // left_q counts down the reads still allowed in this burst; the burst
    // closes on the read that takes it from 1 to 0, and that read still happens.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        left_d  = left_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (sel_found && !bus.fifo_empty) begin
                    state_d        = BURST;
                    gnt_d[sel_idx] = 1'b1;
                    idx_d          = sel_idx;
                    left_d         = CW'(BURST_MAX);
                end
            end
            BURST: begin
                if ((rd && (left_q == CW'(1))) || !granted_req || bus.fifo_empty) begin
                    // last moves only here, so an empty-FIFO cut still rotates
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = idx_q;
                    left_d  = '0;
                end else if (rd) begin
                    left_d = left_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                left_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            last_q   <= LW'(NREQ - 1);
            left_q   <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            left_q   <= left_d;
            rvalid_q <= {NREQ{rd}} & gnt_q;
        end
    end

    assign bus.fifo_rd = rd;
    assign bus.gnt     = gnt_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = bus.fifo_rdata[DW-1:0];
    assign bus.busy    = (state_q == BURST);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_arbiter
// Directed bench for fifo_read_arbiter (NREQ=4, DW=16, BURST_MAX=4) with a
// small behavioural FIFO whose read data appears one cycle after fifo_rd.
// -----------------------------------------------------------------------------
module tb_fifo_read_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_read_arbiter_if #(.NREQ(4), .DW(16)) bus ();

    fifo_read_arbiter #(.NREQ(4), .DW(16), .BURST_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // behavioural FIFO
    logic [15:0] mem [0:127];
    int wr_ptr, rd_ptr, fifo_cnt;

    assign bus.fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (bus.fifo_rd === 1'b1) begin
            bus.fifo_rdata <= mem[rd_ptr % 128];
            rd_ptr         <= rd_ptr + 1;
            fifo_cnt       <= fifo_cnt - 1;
        end
    end

    // monitor logs
    int gnt_log[$];
    int rd_log[$];
    int gap_log[$];
    int dv_idx[$];
    int dv_dat[$];
    int viol;
    int gap;
    bit seen;
    logic [3:0] prev_gnt;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic int oh2i(logic [3:0] v);
        int n = 0;
        int r = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                n++;
                r = i;
            end
        end
        return (n == 1) ? r : -1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fifo_rd && bus.fifo_empty) viol++;
            if (bus.gnt != 4'b0 && prev_gnt != 4'b0 && bus.gnt != prev_gnt) viol++;
            if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
                gnt_log.push_back(oh2i(bus.gnt));
                if (seen) gap_log.push_back(gap);
                seen = 1'b1;
                rd_log.push_back(0);
            end
            if (bus.gnt == 4'b0) gap++;
            else gap = 0;
            if (bus.fifo_rd && rd_log.size() > 0) begin
                int t;
                t = rd_log.pop_back();
                rd_log.push_back(t + 1);
            end
            if (bus.rvalid != 4'b0) begin
                dv_idx.push_back(oh2i(bus.rvalid));
                dv_dat.push_back(int'(bus.rdata));
            end
            prev_gnt = bus.gnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int q[$], input int exp[$]);
        chk({tag, ".size"}, q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : -1, exp[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [15:0] d);
        mem[wr_ptr % 128] = d;
        wr_ptr++;
        fifo_cnt++;
    endtask

    task automatic flush();
        rd_ptr   = wr_ptr;
        fifo_cnt = 0;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rd_log.delete();
        gap_log.delete();
        dv_idx.delete();
        dv_dat.delete();
        viol     = 0;
        gap      = 0;
        seen     = 1'b0;
        prev_gnt = 4'b0;
    endtask

    task automatic do_reset();
        bus.req = 4'b0;
        rst_n   = 1'b0;
        steps(2);
        rst_n = 1'b1;
        step();
    endtask

    int e_g[$], e_r[$], e_p[$], e_i[$], e_d[$];
    int cnt1;

    initial begin
        rst_n          = 1'b0;
        bus.req        = 4'hF;
        bus.fifo_rdata = 16'h0;
        wr_ptr = 0; rd_ptr = 0; fifo_cnt = 0;
        clear_logs();

        // reset state, with requests and data present
        step();
        push(16'hdead);
        steps(2);
        chk("rst.gnt", bus.gnt, 4'b0);
        chk("rst.rvalid", bus.rvalid, 4'b0);
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.fifo_rd", bus.fifo_rd, 1'b0);
        bus.req = 4'b0;
        flush();
        rst_n = 1'b1;
        step();

        // single requester, 3 words, burst cut by empty FIFO
        clear_logs();
        push(16'h0011); push(16'h0012); push(16'h0013);
        bus.req = 4'b0001;
        step();
        chk("s1.gnt", bus.gnt, 4'b0001);
        chk("s1.busy", bus.busy, 1'b1);
        steps(8);
        chk("s1.gnt_end", bus.gnt, 4'b0);
        chk("s1.busy_end", bus.busy, 1'b0);
        e_g = '{0}; e_r = '{3}; e_i = '{0, 0, 0}; e_d = '{16'h11, 16'h12, 16'h13};
        chk_q("s1.grants", gnt_log, e_g);
        chk_q("s1.reads", rd_log, e_r);
        chk_q("s1.dv_idx", dv_idx, e_i);
        chk_q("s1.dv_dat", dv_dat, e_d);
        chk("s1.viol", viol, 0);
        bus.req = 4'b0;

        // req 0 and 2, 16 words
        do_reset();
        clear_logs();
        for (int k = 0; k < 16; k++) push(16'h0200 + 16'(k));
        bus.req = 4'b0101;
        steps(30);
        e_g = '{0, 2, 0, 2}; e_r = '{4, 4, 4, 4}; e_p = '{1, 1, 1};
        e_i.delete(); e_d.delete();
        for (int k = 0; k < 16; k++) begin
            e_i.push_back(((k / 4) % 2 == 0) ? 0 : 2);
            e_d.push_back(16'h0200 + k);
        end
        chk_q("s2.grants", gnt_log, e_g);
        chk_q("s2.reads", rd_log, e_r);
        chk_q("s2.gaps", gap_log, e_p);
        chk_q("s2.dv_idx", dv_idx, e_i);
        chk_q("s2.dv_dat", dv_dat, e_d);
        chk("s2.viol", viol, 0);
        bus.req = 4'b0;

        // all four, 32 words
        do_reset();
        clear_logs();
        for (int k = 0; k < 32; k++) push(16'h0300 + 16'(k));
        bus.req = 4'b1111;
        steps(50);
        e_g.delete(); e_r.delete(); e_p.delete(); e_i.delete(); e_d.delete();
        for (int k = 0; k < 8; k++) begin
            e_g.push_back(k % 4);
            e_r.push_back(4);
            if (k > 0) e_p.push_back(1);
        end
        for (int k = 0; k < 32; k++) begin
            e_i.push_back((k / 4) % 4);
            e_d.push_back(16'h0300 + k);
        end
        chk_q("s3.grants", gnt_log, e_g);
        chk_q("s3.reads", rd_log, e_r);
        chk_q("s3.gaps", gap_log, e_p);
        chk_q("s3.dv_idx", dv_idx, e_i);
        chk_q("s3.dv_dat", dv_dat, e_d);
        chk("s3.viol", viol, 0);
        bus.req = 4'b0;

        // req[1] dropped after two reads; req[2] takes the rest
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) push(16'h0400 + 16'(k));
        bus.req = 4'b0110;
        step();
        chk("s4.gnt", bus.gnt, 4'b0010);
        steps(2);
        bus.req = 4'b0100;
        steps(12);
        e_g = '{1, 2}; e_r = '{2, 2}; e_i = '{1, 1, 2, 2};
        e_d = '{16'h400, 16'h401, 16'h402, 16'h403};
        chk_q("s4.grants", gnt_log, e_g);
        chk_q("s4.reads", rd_log, e_r);
        chk_q("s4.dv_idx", dv_idx, e_i);
        chk_q("s4.dv_dat", dv_dat, e_d);
        cnt1 = 0;
        foreach (dv_idx[i]) if (dv_idx[i] == 1) cnt1++;
        chk("s4.rvalid1_cnt", cnt1, 2);
        chk("s4.busy_end", bus.busy, 1'b0);
        chk("s4.viol", viol, 0);
        bus.req = 4'b0;

        // FIFO runs dry mid-burst, refill hands over to the next requester
        do_reset();
        clear_logs();
        push(16'h0500); push(16'h0501);
        bus.req = 4'b0011;
        steps(6);
        chk("s5.busy_dry", bus.busy, 1'b0);
        chk("s5.gnt_dry", bus.gnt, 4'b0);
        for (int k = 2; k < 6; k++) push(16'h0500 + 16'(k));
        steps(10);
        e_g = '{0, 1}; e_r = '{2, 4}; e_i = '{0, 0, 1, 1, 1, 1};
        e_d = '{16'h500, 16'h501, 16'h502, 16'h503, 16'h504, 16'h505};
        chk_q("s5.grants", gnt_log, e_g);
        chk_q("s5.reads", rd_log, e_r);
        chk_q("s5.dv_idx", dv_idx, e_i);
        chk_q("s5.dv_dat", dv_dat, e_d);
        chk("s5.viol", viol, 0);
        bus.req = 4'b0;

        // reset asserted with a read in flight
        do_reset();
        clear_logs();
        for (int k = 0; k < 8; k++) push(16'h0600 + 16'(k));
        bus.req = 4'b1000;
        step();
        chk("s6.gnt", bus.gnt, 4'b1000);
        step();
        chk("s6.fifo_rd", bus.fifo_rd, 1'b1);
        chk("s6.rvalid", bus.rvalid, 4'b1000);
        #1 rst_n = 1'b0;
        #1;
        chk("s6.async_gnt", bus.gnt, 4'b0);
        chk("s6.async_fifo_rd", bus.fifo_rd, 1'b0);
        chk("s6.async_rvalid", bus.rvalid, 4'b0);
        chk("s6.async_busy", bus.busy, 1'b0);
        step();
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        step();
        chk("s6.gnt_after", bus.gnt, 4'b0001);
        bus.req = 4'b0;
        flush();
        steps(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
